// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and the memory responder.
// The CPU drives the request fields: req, wr, Address and WriteData.
// The responder drives the response fields: ReadData, ready, err and busy.
//   master - CPU side: drives the request fields, receives the response fields.
//   slave  - responder side: receives the request fields, drives the response fields.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, wr, Address, WriteData,
    input  ReadData, ready, err, busy
  );

  modport slave (
    input  req, wr, Address, WriteData,
    output ReadData, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU's data/instruction port.
// It accepts one 32-bit word read or write request, waits LATENCY wait states,
// and then ends the request with a one-cycle ready pulse. A misaligned address,
// or one past the end of the array, gives an immediate error response and the
// array is not accessed.
// Ports:
//   clock - system clock; all state changes on its rising edge
//   reset - synchronous, active-high reset
//   bus   - slave side of mem_responder_if
//           inputs:  req, wr, Address, WriteData
//           outputs: ReadData, ready, err, busy
// Parameters:
//   DEPTH_WORDS - number of 32-bit words in the array; must be a power of two
//   LATENCY     - wait-state cycles between acceptance and response, 0..15
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               addr_bad;
  logic               acc_go;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;

  // Out of range means any word-index bit above the array's index width is set.
  assign addr_bad = (bus.Address[1:0] != 2'b00) || (|bus.Address[31:IDX_W+2]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    acc_go    = 1'b0;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          wr_d    = bus.wr;
          idx_d   = bus.Address[IDX_W+1:2];
          wdata_d = bus.WriteData;
          err_d   = addr_bad;
          if (addr_bad) begin
            state_d = RESP;
          end else if (LATENCY == 0) begin
            // No wait states: the access uses the live request fields,
            // because the latched copies only become visible after this edge.
            state_d   = RESP;
            acc_go    = 1'b1;
            acc_wr    = bus.wr;
            acc_idx   = bus.Address[IDX_W+1:2];
            acc_wdata = bus.WriteData;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_go && !acc_wr) begin
      rdata_d = mem[acc_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields and the array have no reset. A write whose commit
  // edge coincides with reset is dropped.
  always_ff @(posedge clock) begin
    wr_q    <= wr_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    if (acc_go && acc_wr && !reset) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign bus.ready    = (state_q == RESP);
  assign bus.err      = (state_q == RESP) && err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ReadData = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances share one stimulus:
// one is built with LATENCY=2 and one with LATENCY=0, and a select chooses
// which instance's outputs are checked. A reference model predicts every
// response from the memory contents and the latency rules, held in an
// associative array of words.
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  assign bus2.req = req;
  assign bus2.wr = wr;
  assign bus2.Address = addr;
  assign bus2.WriteData = wdata;
  assign bus0.req = req;
  assign bus0.wr = wr;
  assign bus0.Address = addr;
  assign bus0.WriteData = wdata;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus2)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  bit          sel0 = 1'b0;
  logic        obs_ready, obs_err, obs_busy;
  logic [31:0] obs_rdata;
  assign obs_ready = sel0 ? bus0.ready : bus2.ready;
  assign obs_err   = sel0 ? bus0.err : bus2.err;
  assign obs_busy  = sel0 ? bus0.busy : bus2.busy;
  assign obs_rdata = sel0 ? bus0.ReadData : bus2.ReadData;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;
  bit          rd_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge with the responder idle, then follow it to its response.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d);
    bit bad;
    int exp_lat;
    int n;
    int k;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    exp_lat = bad ? 1 : (sel0 ? 1 : LAT + 1);
    k = int'(a[9:2]);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clock); #1;
    req = 1'b0; wr = 1'($urandom); addr = $urandom; wdata = $urandom;
    @(negedge clock);
    n = 1;
    while (!obs_ready && n < 20) begin
      chk("busy_wait", 32'(obs_busy), 32'd1);
      @(negedge clock);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("err", 32'(obs_err), 32'(bad));
    chk("busy_resp", 32'(obs_busy), 32'd1);
    if (!bad && w) begin
      ref_mem[k] = d;
      if (rd_known) chk("rd_hold_wr", obs_rdata, ref_rd);
    end else if (!bad && !w) begin
      if (ref_mem.exists(k)) begin
        chk("rdata", obs_rdata, ref_mem[k]);
        ref_rd = ref_mem[k];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
    end else if (rd_known) begin
      chk("rd_hold_err", obs_rdata, ref_rd);
    end
    @(negedge clock);
    chk("idle_ready", 32'(obs_ready), 32'd0);
    chk("idle_busy", 32'(obs_busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    logic [31:0] cur;
    logic [31:0] old20;
    logic [31:0] a;
    int r;

    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(bus2.ready), 32'd0);
    chk("rst_err", 32'(bus2.err), 32'd0);
    chk("rst_busy", 32'(bus2.busy), 32'd0);
    chk("rst_rdata", bus2.ReadData, 32'h0);
    chk("rst0_ready", 32'(bus0.ready), 32'd0);
    chk("rst0_rdata", bus0.ReadData, 32'h0);
    reset = 1'b0;
    ref_rd = 32'h0;
    rd_known = 1'b1;

    // Fill a small region so later reads have known contents.
    for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), $urandom);

    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b0, 32'h12, 32'h0);
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b0, 32'h400, 32'h0);
    do_req(1'b0, 32'h10, 32'h0);

    // Randomized mix of in-range, misaligned and out-of-range accesses.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 32'h400 : (($urandom & 32'hFFFF_FFFC) | 32'h400);
      else a = 32'($urandom_range(0, 15)) << 2;
      do_req(1'($urandom), a, $urandom);
    end

    // req held high: reads alternate between 0x0 and 0x4.
    req = 1'b1; wr = 1'b0; cur = 32'h0; addr = cur;
    pulses = 0;
    last_pulse = 0;
    for (int cyc = 1; cyc <= 40 && pulses < 5; cyc++) begin
      @(negedge clock);
      if (obs_ready) begin
        if (pulses == 0) chk("held_first", 32'(cyc), 32'(LAT + 1));
        else chk("held_period", 32'(cyc - last_pulse), 32'(LAT + 2));
        chk("held_rdata", obs_rdata, ref_mem[int'(cur[9:2])]);
        ref_rd = ref_mem[int'(cur[9:2])];
        pulses++;
        last_pulse = cyc;
        cur = cur ^ 32'h4;
        addr = cur;
        if (pulses == 5) req = 1'b0;
      end else if (pulses > 0) begin
        chk("held_busy", 32'(obs_busy), (cyc - last_pulse == 1) ? 32'd0 : 32'd1);
      end
    end
    chk("held_pulses", 32'(pulses), 32'd5);
    @(negedge clock);

    // Reset lands on the commit edge of a write to 0x20.
    old20 = ref_mem[8];
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clock); #1;
    req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_ready", 32'(obs_ready), 32'd0);
    chk("rstmid_busy", 32'(obs_busy), 32'd0);
    chk("rstmid_rdata", obs_rdata, 32'h0);
    ref_rd = 32'h0;
    rd_known = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rstmid_noready", 32'(obs_ready), 32'd0);
    end
    do_req(1'b0, 32'h20, 32'h0);
    chk("rstmid_old", obs_rdata, old20);

    // Zero-latency instance.
    sel0 = 1'b1;
    rd_known = 1'b0;
    do_req(1'b1, 32'h8, 32'hCAFEF00D);
    do_req(1'b0, 32'h8, 32'h0);
    chk("lat0_rdata", obs_rdata, 32'hCAFEF00D);
    do_req(1'b0, 32'h9, 32'h0);
    do_req(1'b0, 32'h400, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
